// File: rtl/word_packer.sv
// -----------------------------------------------------------------------------
// word_packer
//
// Serial-to-parallel front end for the pairwise multiply / adder-tree datapath.
// It collects one NB_DATA-bit word per accepted handshake and packs up to
// N_WORDS words into one flat vector. Word k sits at
// o_data[(k+1)*NB_DATA-1 -: NB_DATA]. The completed frame is held stable until
// downstream takes it, so the combinational multiplier stage sees a constant
// operand vector while it consumes the frame.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clock edge where valid && ready are both 1.
//   Input side : a word is taken when i_valid && o_ready.
//   Output side: the frame is taken when o_valid && i_ready.
//   A valid source holds its payload until that edge. i_last and i_ready
//   have no effect when their partner signal is low.
//
// Ports:
//   clock    in   rising-edge clock
//   reset    in   asynchronous, active-low reset
//   i_data   in   [NB_DATA-1:0] input word (opaque bits)
//   i_valid  in   i_data is valid this cycle
//   i_last   in   final word of a short frame (qualified by i_valid)
//   i_clear  in   synchronous flush; highest priority over accept/transfer
//   o_ready  out  packer accepts a word this cycle (decoded from state only)
//   o_data   out  [N_WORDS*NB_DATA-1:0] packed frame, unwritten slots are 0
//   o_valid  out  o_data holds a complete frame
//   i_ready  in   downstream takes the frame this cycle
//   o_count  out  [$clog2(N_WORDS+1)-1:0] number of real (non-padded) words
//   o_state  out  current FSM state, for observation only
// -----------------------------------------------------------------------------
module word_packer #(
  parameter int N_WORDS = 32,
  parameter int NB_DATA = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NB_DATA-1:0]           i_data,
  input  logic                         i_valid,
  input  logic                         i_last,
  input  logic                         i_clear,
  output logic                         o_ready,
  output logic [N_WORDS*NB_DATA-1:0]   o_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [$clog2(N_WORDS+1)-1:0] o_count,
  output logic [0:0]                   o_state
);

  localparam int PW = $clog2(N_WORDS);
  localparam int CW = $clog2(N_WORDS + 1);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  logic [0:0]    state;
  logic [PW-1:0] wr_ptr;

  // The last slot index; reaching it (or seeing i_last) closes the frame.
  localparam logic [PW-1:0] LAST_SLOT = PW'(N_WORDS - 1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= FILL;
      wr_ptr  <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_count <= '0;
    end else if (i_clear) begin
      // Flush wins over any accept or transfer in the same cycle.
      state   <= FILL;
      wr_ptr  <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_count <= '0;
    end else begin
      case (state)
        FILL: begin
          if (i_valid) begin
            // Decoded slot write keeps every index a constant.
            for (int k = 0; k < N_WORDS; k++) begin
              if (wr_ptr == PW'(k)) begin
                o_data[k*NB_DATA +: NB_DATA] <= i_data;
              end
            end
            o_count <= o_count + CW'(1);
            if (wr_ptr == LAST_SLOT || i_last) begin
              // The pointer is not advanced here so it never passes the
              // last slot; transfer brings it back to 0.
              state   <= FULL;
              o_valid <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + PW'(1);
            end
          end
        end
        FULL: begin
          // Frame is frozen; input words are refused via o_ready=0.
          if (i_ready) begin
            state   <= FILL;
            wr_ptr  <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_count <= '0;
          end
        end
        default: begin
          state   <= FILL;
          wr_ptr  <= '0;
          o_data  <= '0;
          o_valid <= 1'b0;
          o_count <= '0;
        end
      endcase
    end
  end

  assign o_ready = (state == FILL);
  assign o_state = state;

endmodule

// File: tb/tb_word_packer.sv
module tb_word_packer;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // ---------------- small instance (N_WORDS=4) ----------------
  logic [7:0]  i_data  = '0;
  logic        i_valid = 1'b0;
  logic        i_last  = 1'b0;
  logic        i_clear = 1'b0;
  logic        i_ready = 1'b0;
  logic        o_ready;
  logic [31:0] o_data;
  logic        o_valid;
  logic [2:0]  o_count;
  logic [0:0]  o_state;

  word_packer #(.N_WORDS(4), .NB_DATA(8)) dut (
    .clock(clock), .reset(reset),
    .i_data(i_data), .i_valid(i_valid), .i_last(i_last), .i_clear(i_clear),
    .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_count(o_count), .o_state(o_state)
  );

  // ---------------- large instance (N_WORDS=32) ----------------
  logic [7:0]   b_i_data  = '0;
  logic         b_i_valid = 1'b0;
  logic         b_i_last  = 1'b0;
  logic         b_i_clear = 1'b0;
  logic         b_i_ready = 1'b0;
  logic         b_o_ready;
  logic [255:0] b_o_data;
  logic         b_o_valid;
  logic [5:0]   b_o_count;
  logic [0:0]   b_o_state;

  word_packer #(.N_WORDS(32), .NB_DATA(8)) dut_big (
    .clock(clock), .reset(reset),
    .i_data(b_i_data), .i_valid(b_i_valid), .i_last(b_i_last), .i_clear(b_i_clear),
    .o_ready(b_o_ready), .o_data(b_o_data), .o_valid(b_o_valid),
    .i_ready(b_i_ready), .o_count(b_o_count), .o_state(b_o_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the frame is simply the list of accepted words plus a
  // "frame complete" flag. Packing is done from the list on demand.
  logic [7:0] exp_q[$];
  bit         m_full = 1'b0;

  function automatic logic [31:0] model_frame();
    logic [31:0] r = '0;
    foreach (exp_q[i]) r[i*8 +: 8] = exp_q[i];
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_full = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, o_valid, m_full);
    check({tag, "_ready"}, o_ready, !m_full);
    check({tag, "_count"}, o_count, exp_q.size());
    check({tag, "_data"},  o_data,  model_frame());
  endtask

  // One clock of stimulus on the small instance, model update, then check.
  task automatic step(input logic v, input logic [7:0] d, input logic l,
                      input logic c, input logic r, input string tag);
    i_valid = v; i_data = d; i_last = l; i_clear = c; i_ready = r;
    @(posedge clock);
    if (c) begin
      model_reset();
    end else if (m_full) begin
      if (r) model_reset();
    end else if (v) begin
      exp_q.push_back(d);
      if (exp_q.size() == 4 || l) m_full = 1'b1;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0; i_data = '0; i_last = 1'b0; i_clear = 1'b0; i_ready = 1'b0;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset(input string tag);
    idle_inputs();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    check({tag, "_big_valid"}, b_o_valid, 1'b0);
    check({tag, "_big_data"},  b_o_data, 256'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [255:0] big_exp;

    // Reset state while reset is held low
    #1;
    model_reset();
    check_outputs("rst");
    check("rst_big_ready", b_o_ready, 1'b1);
    check("rst_big_count", b_o_count, 6'd0);
    #3;
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Back-to-back full frame, transfer right away
    step(1, 8'h01, 0, 0, 1, "t2a");
    step(1, 8'h02, 0, 0, 1, "t2b");
    step(1, 8'h03, 0, 0, 1, "t2c");
    step(1, 8'h04, 0, 0, 1, "t2d");
    check("t2_data_lit",  o_data,  32'h04030201);
    check("t2_count_lit", o_count, 3'd4);
    step(0, 8'h00, 0, 0, 1, "t2x");
    check("t2_after_data", o_data, 32'h0);

    // Full frame held with i_ready=0 while FF is offered
    for (int i = 1; i <= 4; i++) step(1, 8'(i * 16), 0, 0, 0, "t3f");
    for (int i = 0; i < 5; i++) step(1, 8'hFF, 0, 0, 0, "t3h");
    check("t3_hold_lit", o_data, 32'h40302010);
    step(1, 8'hFF, 0, 0, 1, "t3x");
    check("t3_after_ready", o_ready, 1'b1);

    // Short frame with i_last
    step(1, 8'hAA, 0, 0, 0, "t4a");
    step(1, 8'hBB, 1, 0, 0, "t4b");
    check("t4_data_lit", o_data, 32'h0000BBAA);
    step(0, 8'h00, 0, 0, 1, "t4x");

    // i_last without i_valid is ignored
    step(0, 8'h77, 1, 0, 0, "tla");
    step(1, 8'h99, 1, 0, 0, "tlb");
    step(0, 8'h00, 0, 0, 1, "tlx");

    // Gapped input
    step(1, 8'h11, 0, 0, 1, "t5a"); step(0, 8'h00, 0, 0, 1, "t5g");
    step(1, 8'h22, 0, 0, 1, "t5b"); step(0, 8'h00, 0, 0, 0, "t5g");
    step(0, 8'h00, 0, 0, 0, "t5g"); step(1, 8'h33, 0, 0, 0, "t5c");
    step(1, 8'h44, 0, 0, 0, "t5d");
    check("t5_data_lit", o_data, 32'h44332211);
    step(0, 8'h00, 0, 0, 1, "t5x");

    // Clear mid-frame, then a fresh frame
    step(1, 8'hC1, 0, 0, 0, "t6a");
    step(1, 8'hC2, 0, 0, 0, "t6b");
    step(0, 8'h00, 0, 1, 0, "t6c");
    for (int i = 5; i <= 8; i++) step(1, 8'(i), 0, 0, 0, "t6f");
    check("t6_data_lit",  o_data,  32'h08070605);
    check("t6_count_lit", o_count, 3'd4);
    // Clear coinciding with a transfer
    step(0, 8'h00, 0, 1, 1, "t6ct");
    check("t6ct_state", o_state, 1'b0);

    // Reset mid-frame, then a fresh frame
    step(1, 8'hD1, 0, 0, 0, "t1a");
    step(1, 8'hD2, 0, 0, 0, "t1b");
    async_reset("t1r");
    for (int i = 5; i <= 8; i++) step(1, 8'(i), 0, 0, 0, "t1f");
    check("t1_data_lit", o_data, 32'h08070605);
    // Reset while a frame is held
    async_reset("t1h");

    // Clear while the first word is offered overrides the accept
    step(1, 8'h5A, 0, 1, 0, "tcacc");

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, "rnd");
    end
    idle_inputs();

    // Large instance: stream 1..32
    big_exp = '0;
    for (int i = 1; i <= 32; i++) begin
      b_i_valid = 1'b1;
      b_i_data  = 8'(i);
      big_exp[(i-1)*8 +: 8] = 8'(i);
      @(posedge clock);
      #1;
    end
    b_i_valid = 1'b0;
    check("t7_valid", b_o_valid, 1'b1);
    check("t7_ready", b_o_ready, 1'b0);
    check("t7_count", b_o_count, 6'd32);
    check("t7_top",   b_o_data[255:248], 8'h20);
    check("t7_bot",   b_o_data[7:0], 8'h01);
    check("t7_data",  b_o_data, big_exp);
    b_i_ready = 1'b1;
    @(posedge clock);
    #1;
    b_i_ready = 1'b0;
    check("t7_x_valid", b_o_valid, 1'b0);
    check("t7_x_data",  b_o_data, 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
